// File: rtl/pulse_counter_pkg.sv
// ----------------------------------------------------------------------------
// pulse_counter_pkg
// Shared constants for the multi-channel pulse counter: register offsets,
// mode encoding, channel limit and a small address decoder helper.
// No ports (package).
// ----------------------------------------------------------------------------
package pulse_counter_pkg;

    localparam int MAX_CH = 32;

    // Byte offsets of the register map
    localparam logic [9:0] REG_EN         = 10'h000;
    localparam logic [9:0] REG_MODE       = 10'h004;
    localparam logic [9:0] REG_CLR        = 10'h008;
    localparam logic [9:0] REG_OVF        = 10'h00C;
    localparam logic [9:0] REG_IE         = 10'h010;
    localparam logic [9:0] REG_COUNT_BASE = 10'h100;

    // Per-channel MODE bit encoding
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_EN,
        SEL_MODE,
        SEL_CLR,
        SEL_OVF,
        SEL_IE,
        SEL_COUNT
    } reg_sel_e;

    // Word-aligned decode; addr[1:0] never takes part. COUNT slots that
    // belong to channels that do not exist decode as unmapped.
    function automatic reg_sel_e decode(input logic [9:0] a, input int num_ch);
        int word;
        int base;
        word = int'(a[9:2]);
        base = int'(REG_COUNT_BASE[9:2]);
        if (word == int'(REG_EN[9:2]))        return SEL_EN;
        else if (word == int'(REG_MODE[9:2])) return SEL_MODE;
        else if (word == int'(REG_CLR[9:2]))  return SEL_CLR;
        else if (word == int'(REG_OVF[9:2]))  return SEL_OVF;
        else if (word == int'(REG_IE[9:2]))   return SEL_IE;
        else if (word >= base && word < base + num_ch) return SEL_COUNT;
        else return SEL_NONE;
    endfunction

endpackage

// File: rtl/pulse_counter_mc_channel.sv
// ----------------------------------------------------------------------------
// pulse_channel
// One counting channel: rising-edge detector, CNT_W-bit counter with
// wrap/saturate behaviour and a single-cycle overflow-set pulse.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   pulse     : pulse source (synchronous to clk)
//   en        : channel enable
//   mode      : MODE_WRAP / MODE_SAT
//   clr       : clear count this cycle (wins over an increment)
//   count     : current count
//   ovf_set   : combinational, high in the cycle an edge hits a full counter
// ----------------------------------------------------------------------------
module pulse_channel
    import pulse_counter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf_set
);

    logic pulse_q;
    logic edge_hit;
    logic inc;
    logic at_max;

    assign edge_hit = pulse & ~pulse_q;
    assign inc      = edge_hit & en;
    assign at_max   = (count == {CNT_W{1'b1}});

    // A clear swallows the edge entirely, so it cannot overflow either.
    assign ovf_set  = inc & at_max & ~clr;

    // pulse_q resets high so a source held high through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b1;
            count   <= '0;
        end else begin
            pulse_q <= pulse;
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                if (!at_max) begin
                    count <= count + CNT_W'(1);
                end else if (mode == MODE_WRAP) begin
                    count <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_counter_mc.sv
// ----------------------------------------------------------------------------
// pulse_counter_mc
// Multi-channel pulse counter with a simple register bus. Holds the register
// file (EN, MODE, OVF, IE), the CLR strobe, the read mux and the irq output;
// the per-channel counting lives in pulse_channel.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : single-cycle write strobe
//   rd_en     : single-cycle read strobe
//   addr      : byte address (addr[1:0] ignored)
//   wdata     : write data
//   rdata     : registered read data, held until the next rd_en
//   pulse_in  : NUM_CH pulse sources
//   irq       : registered level interrupt, |(OVF & IE)
// ----------------------------------------------------------------------------
module pulse_counter_mc
    import pulse_counter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [9:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic              irq
);

    reg_sel_e          sel;
    logic [NUM_CH-1:0] wr_bits;
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] ovf_r;
    logic [NUM_CH-1:0] ie_r;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] ovf_set;
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [31:0]       rd_val;
    logic              bus_unused;

    // Byte lanes below the word and data bits above NUM_CH carry no meaning.
    assign bus_unused = ^{addr[1:0], wdata};

    assign sel     = decode(addr, NUM_CH);
    assign wr_bits = wdata[NUM_CH-1:0];
    assign clr     = (wr_en && sel == SEL_CLR) ? wr_bits : '0;
    assign w1c     = (wr_en && sel == SEL_OVF) ? wr_bits : '0;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pulse_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .pulse   (pulse_in[ch]),
            .en      (en_r[ch]),
            .mode    (mode_r[ch]),
            .clr     (clr[ch]),
            .count   (count[ch]),
            .ovf_set (ovf_set[ch])
        );
    end

    // Read mux works on current register values, so a read that coincides
    // with a write to the same address returns the pre-write contents.
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_EN:   rd_val[NUM_CH-1:0] = en_r;
            SEL_MODE: rd_val[NUM_CH-1:0] = mode_r;
            SEL_OVF:  rd_val[NUM_CH-1:0] = ovf_r;
            SEL_IE:   rd_val[NUM_CH-1:0] = ie_r;
            SEL_COUNT: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr[6:2] == 5'(i)) begin
                        rd_val[CNT_W-1:0] = count[i];
                    end
                end
            end
            default:  rd_val = '0;
        endcase
    end

    // Register file, sticky overflow (a new set outranks a same-cycle W1C),
    // registered irq and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r   <= '0;
            mode_r <= '0;
            ovf_r  <= '0;
            ie_r   <= '0;
            irq    <= 1'b0;
            rdata  <= '0;
        end else begin
            if (wr_en) begin
                case (sel)
                    SEL_EN:   en_r   <= wr_bits;
                    SEL_MODE: mode_r <= wr_bits;
                    SEL_IE:   ie_r   <= wr_bits;
                    default:  ;
                endcase
            end
            ovf_r <= (ovf_r & ~w1c) | ovf_set;
            irq   <= |(ovf_r & ie_r);
            if (rd_en) begin
                rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_pulse_counter_mc.sv
// ----------------------------------------------------------------------------
// tb_pulse_counter_mc
// Scoreboard bench: each stimulus cycle updates a behavioural model of the
// counter and queues the expected irq and (for reads) rdata; a monitor
// compares against the DUT on the falling edge.
// ----------------------------------------------------------------------------
module tb_pulse_counter_mc;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 4;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [9:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pulse_in = '0;
    logic              irq;

    always #5 clk = ~clk;

    pulse_counter_mc #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .pulse_in (pulse_in),
        .irq      (irq)
    );

    typedef struct {
        logic [9:0]  a;
        logic [31:0] v;
    } rd_exp_t;

    rd_exp_t rd_q [$];
    logic    irq_q [$];
    bit      rd_pending = 1'b0;
    int      checks = 0;
    int      errors = 0;

    // Behavioural model state
    int                cnt_m [NUM_CH];
    logic [NUM_CH-1:0] en_m, mode_m, ovf_m, ie_m, prev_m;

    logic [9:0] addr_pool [13] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010,
                                   10'h014, 10'h100, 10'h104, 10'h108, 10'h10C,
                                   10'h110, 10'h200, 10'h3FC};

    // Expected read result from the register map, using current model state
    function automatic logic [31:0] read_model(input logic [9:0] a);
        logic [31:0] v;
        int w;
        v = '0;
        w = int'(a[9:2]);
        case (w)
            0: v[NUM_CH-1:0] = en_m;
            1: v[NUM_CH-1:0] = mode_m;
            3: v[NUM_CH-1:0] = ovf_m;
            4: v[NUM_CH-1:0] = ie_m;
            default: if (w >= 64 && w < 64 + NUM_CH) v = 32'(cnt_m[w - 64]);
        endcase
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge
    task automatic apply_stimulus(input logic r, input logic w, input logic rd,
                                  input logic [9:0] a, input logic [31:0] d,
                                  input logic [NUM_CH-1:0] p);
        logic [NUM_CH-1:0] clr_hit, w1c, set;
        int word;
        rst = r; wr_en = w; rd_en = rd; addr = a; wdata = d; pulse_in = p;
        if (r) begin
            irq_q.push_back(1'b0);
            for (int c = 0; c < NUM_CH; c++) cnt_m[c] = 0;
            en_m = '0; mode_m = '0; ovf_m = '0; ie_m = '0; prev_m = '1;
        end else begin
            irq_q.push_back(|(ovf_m & ie_m));
            if (rd) rd_q.push_back('{a, read_model(a)});
            word    = int'(a[9:2]);
            clr_hit = (w && word == 2) ? d[NUM_CH-1:0] : '0;
            w1c     = (w && word == 3) ? d[NUM_CH-1:0] : '0;
            set     = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_hit[c]) begin
                    cnt_m[c] = 0;
                end else if (p[c] && !prev_m[c] && en_m[c]) begin
                    if (cnt_m[c] + 1 > MAX_CNT) set[c] = 1'b1;
                    if (mode_m[c]) cnt_m[c] = (cnt_m[c] + 1 > MAX_CNT) ? MAX_CNT : cnt_m[c] + 1;
                    else           cnt_m[c] = (cnt_m[c] + 1) % (MAX_CNT + 1);
                end
            end
            if (w && word == 0) en_m   = d[NUM_CH-1:0];
            if (w && word == 1) mode_m = d[NUM_CH-1:0];
            if (w && word == 4) ie_m   = d[NUM_CH-1:0];
            ovf_m  = (ovf_m & ~w1c) | set;
            prev_m = p;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [9:0] a, input logic [31:0] d);
        apply_stimulus(1'b0, 1'b1, 1'b0, a, d, '0);
    endtask

    task automatic read_reg(input logic [9:0] a);
        apply_stimulus(1'b0, 1'b0, 1'b1, a, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic pulse_edges(input logic [NUM_CH-1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, mask);
            apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    // Remember whether a read was issued in the cycle that just ended
    always @(posedge clk) rd_pending = rd_en;

    // Monitor: irq is checked every cycle, rdata after every read
    always @(negedge clk) begin
        rd_exp_t e;
        if (irq_q.size() > 0) check_output("irq", 32'(irq), 32'(irq_q.pop_front()));
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rdata: got %h expected <no read queued>", rdata);
            end else begin
                e = rd_q.pop_front();
                check_output($sformatf("rdata@%h", e.a), rdata, e.v);
            end
        end
    end

    initial begin
        // Reset with all pulses high; they stay high past release
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h000, '0, '1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h004, '0, '1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h008, '0, '1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h00C, '0, '1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h010, '0, '1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h000, 32'hF, '1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '1);
        for (int c = 0; c < NUM_CH; c++) apply_stimulus(1'b0, 1'b0, 1'b1, 10'(10'h100 + 4 * c), '0, '1);
        write_reg(10'h000, 32'h0);

        // Wrap overflow on ch0 with interrupt enabled
        write_reg(10'h004, 32'h0);
        write_reg(10'h010, 32'h1);
        write_reg(10'h000, 32'h1);
        pulse_edges(4'h1, 17);
        read_reg(10'h100);
        read_reg(10'h00C);

        // Saturate on ch1, then W1C its overflow
        write_reg(10'h00C, 32'h1);
        write_reg(10'h010, 32'h3);
        write_reg(10'h004, 32'h2);
        write_reg(10'h000, 32'h2);
        pulse_edges(4'h2, 20);
        read_reg(10'h104);
        read_reg(10'h00C);
        write_reg(10'h00C, 32'h2);
        idle(3);
        read_reg(10'h00C);

        // CLR in the same cycle as an edge on ch2
        write_reg(10'h000, 32'h4);
        pulse_edges(4'h4, 5);
        read_reg(10'h108);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h008, 32'h4, 4'h4);
        idle(1);
        read_reg(10'h108);

        // W1C of ch0 in the same cycle as a fresh ch0 overflow
        write_reg(10'h004, 32'h0);
        write_reg(10'h008, 32'hF);
        write_reg(10'h00C, 32'hF);
        write_reg(10'h000, 32'h1);
        pulse_edges(4'h1, 15);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h00C, 32'h1, 4'h1);
        idle(1);
        read_reg(10'h00C);
        read_reg(10'h100);

        // Partial enable, unmapped accesses, same-cycle read/write
        write_reg(10'h008, 32'hF);
        write_reg(10'h00C, 32'hF);
        write_reg(10'h000, 32'h5);
        pulse_edges(4'hF, 3);
        for (int c = 0; c < NUM_CH; c++) read_reg(10'(10'h100 + 4 * c));
        read_reg(10'h200);
        write_reg(10'h014, 32'hFFFF_FFFF);
        read_reg(10'h014);
        read_reg(10'h000);
        apply_stimulus(1'b0, 1'b1, 1'b1, 10'h010, 32'h9, '0);
        read_reg(10'h010);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] a;
            logic w, r;
            a = addr_pool[$urandom_range(0, 12)] | 10'($urandom_range(0, 3));
            w = ($urandom_range(0, 99) < 25);
            r = ($urandom_range(0, 99) < 35);
            if (w && a[9:2] == 8'h02 && $urandom_range(0, 3) != 0) w = 1'b0;
            apply_stimulus(1'b0, w, r, a, $urandom, NUM_CH'($urandom));
        end

        // Reset mid-operation discards everything
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < NUM_CH; c++) read_reg(10'(10'h100 + 4 * c));
        read_reg(10'h00C);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
